morse_encoder: RTL and testbench
================================

Name: morse_encoder

Overview:
- Transmit-side counterpart of the Morse decoder path.
- Accepts one character code per handshake and drives a single keyed output line.
- The line carries standard Morse timing: dot = 1 unit, dash = 3 units, intra-character gap = 1 unit, inter-character gap = 3 units.
- Feeds the LED/buzzer output stage. It also provides a loopback source for exercising the decoder.

Parameters:
- TICKS_PER_UNIT, 4, CLK cycles per Morse time unit. Legal range ≥ 1; 1,000,000 in the board build.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to send char_code; accepted only when ready=1
- char_code  input  6  0..25 = A..Z; 26..35 = digits 0..9 (see Optional Feature); 36..63 invalid
- ready  output  1  1 when in IDLE and able to accept start
- busy  output  1  always the inverse of ready
- key_out  output  1  registered Morse line; 1 = tone/mark
- done  output  1  one-cycle pulse when a character, including its trailing 3-unit gap, has finished
- err  output  1  one-cycle pulse when start is given with an unsupported code

Behaviour:
- Reset values (after any CLK edge with reset=1): ready=1, busy=0, key_out=0, done=0, err=0, state=IDLE, all counters 0.
- Reset wins over start and aborts any character mid-transmission; key_out=0 on the very next edge.
- Internal ROM maps char_code to:
  - len (1..5 symbols),
  - pattern[4:0] (bit i = symbol i, sent LSB first; 1 = dash, 0 = dot).
  - Letters use standard International Morse, e.g. A=.- , E=. , T=- , S=... , O=---.
- FSM states: IDLE, MARK, GAP, LGAP.
- IDLE:
  - start=1 with a valid code: latch code, sym_idx=0, tick/unit counters=0, go to MARK. key_out=1 starting the next cycle.
  - start=1 with an invalid code: err=1 for the next cycle, remain IDLE, key_out stays 0.
  - start=0: hold.
- MARK:
  - key_out=1 for (dash ? 3 : 1) × TICKS_PER_UNIT cycles.
  - Then go to GAP if sym_idx < len-1 (key_out=0), else go to LGAP.
- GAP:
  - key_out=0 for 1 × TICKS_PER_UNIT cycles.
  - Then sym_idx++ and go to MARK.
- LGAP:
  - key_out=0 for 3 × TICKS_PER_UNIT cycles.
  - Then go to IDLE with done=1 for exactly that first IDLE cycle.
- ready=1 in the done cycle. A start asserted in that cycle is accepted, giving back-to-back characters with exactly a 3-unit gap.
- start while busy is ignored: no latch, no err, no effect on the current character.
- char_code is sampled only on the accepting edge; later changes have no effect.
- Counters:
  - Tick counter width is $clog2(3×TICKS_PER_UNIT+1).
  - Counters reset to 0 on every state transition and never wrap within a state.
- Latency: key_out rises 1 cycle after the accepting edge.
- Total busy cycles for a character = TICKS_PER_UNIT × (Σ symbol units + (len-1) + 3).

Optional Feature:
- Macro: MORSE_DIGITS_EN.
- Defined: codes 26..35 encode digits 0..9 as standard 5-symbol patterns (0=-----, 1=.----, … 9=----.). The sym_idx range is 0..4.
- Undefined: codes 26..35 are invalid and produce the err pulse; ROM and len are restricted to 4 symbols; sym_idx is 2 bits.

Test Plan:
- Reset, then idle 10 cycles -> ready=1, busy=0, key_out=0, done=0, err=0 throughout.
- TICKS_PER_UNIT=4, start with code 0 ('A') at edge 0:
  - key_out=1 cycles 1–4, 0 cycles 5–8, 1 cycles 9–20, 0 cycles 21–32,
  - done=1 and ready=1 at cycle 33.
- Code 4 ('E'), then another start with code 19 ('T') in the done cycle -> E: high 1–4, low 5–16, done at 17; T mark starts cycle 18 for 12 cycles; no extra gap.
- Start with code 40, then code 30 -> err pulse 1 cycle after each, ready stays 1, key_out stays 0. With MORSE_DIGITS_EN, code 30 ('4') instead sends ....- with no err.
- During 'O' (code 14), assert reset for 1 cycle mid-dash -> next cycle key_out=0, ready=1, no done pulse; a new start then works normally.
- Pulse start with code 4 at cycles 3 and 6 while transmitting 'S' (code 18) -> ignored: 'S' timing unchanged, no err, single done.

Source files
------------

// File: rtl/morse_encoder.sv
// Morse character encoder: one char_code per start handshake, drives a keyed line.
// Optional MORSE_DIGITS_EN adds digits 0..9 (codes 26..35) using 5-symbol patterns.
module morse_encoder #(
  parameter int TICKS_PER_UNIT = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] char_code,
  output logic       ready,
  output logic       busy,
  output logic       key_out,
  output logic       done,
  output logic       err
);

`ifdef MORSE_DIGITS_EN
  localparam int MAXSYM = 5;
`else
  localparam int MAXSYM = 4;
`endif
  localparam int SW = $clog2(MAXSYM);
  localparam int CW = $clog2(3 * TICKS_PER_UNIT + 1);
  localparam logic [CW-1:0] UNIT_LAST = CW'(TICKS_PER_UNIT - 1);
  localparam logic [CW-1:0] DASH_LAST = CW'(3 * TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

  // ROM word: {valid, len[2:0], pattern}; pattern bit i is symbol i (1 = dash)
  function automatic logic [MAXSYM+3:0] rom(input logic [5:0] c);
    logic [MAXSYM+3:0] r;
    r = '0;
    case (c)
      6'd0:  r = {1'b1, 3'd2, MAXSYM'(4'b0010)};
      6'd1:  r = {1'b1, 3'd4, MAXSYM'(4'b0001)};
      6'd2:  r = {1'b1, 3'd4, MAXSYM'(4'b0101)};
      6'd3:  r = {1'b1, 3'd3, MAXSYM'(4'b0001)};
      6'd4:  r = {1'b1, 3'd1, MAXSYM'(4'b0000)};
      6'd5:  r = {1'b1, 3'd4, MAXSYM'(4'b0100)};
      6'd6:  r = {1'b1, 3'd3, MAXSYM'(4'b0011)};
      6'd7:  r = {1'b1, 3'd4, MAXSYM'(4'b0000)};
      6'd8:  r = {1'b1, 3'd2, MAXSYM'(4'b0000)};
      6'd9:  r = {1'b1, 3'd4, MAXSYM'(4'b1110)};
      6'd10: r = {1'b1, 3'd3, MAXSYM'(4'b0101)};
      6'd11: r = {1'b1, 3'd4, MAXSYM'(4'b0010)};
      6'd12: r = {1'b1, 3'd2, MAXSYM'(4'b0011)};
      6'd13: r = {1'b1, 3'd2, MAXSYM'(4'b0001)};
      6'd14: r = {1'b1, 3'd3, MAXSYM'(4'b0111)};
      6'd15: r = {1'b1, 3'd4, MAXSYM'(4'b0110)};
      6'd16: r = {1'b1, 3'd4, MAXSYM'(4'b1011)};
      6'd17: r = {1'b1, 3'd3, MAXSYM'(4'b0010)};
      6'd18: r = {1'b1, 3'd3, MAXSYM'(4'b0000)};
      6'd19: r = {1'b1, 3'd1, MAXSYM'(4'b0001)};
      6'd20: r = {1'b1, 3'd3, MAXSYM'(4'b0100)};
      6'd21: r = {1'b1, 3'd4, MAXSYM'(4'b1000)};
      6'd22: r = {1'b1, 3'd3, MAXSYM'(4'b0110)};
      6'd23: r = {1'b1, 3'd4, MAXSYM'(4'b1001)};
      6'd24: r = {1'b1, 3'd4, MAXSYM'(4'b1101)};
      6'd25: r = {1'b1, 3'd4, MAXSYM'(4'b0011)};
`ifdef MORSE_DIGITS_EN
      6'd26: r = {1'b1, 3'd5, 5'b11111};
      6'd27: r = {1'b1, 3'd5, 5'b11110};
      6'd28: r = {1'b1, 3'd5, 5'b11100};
      6'd29: r = {1'b1, 3'd5, 5'b11000};
      6'd30: r = {1'b1, 3'd5, 5'b10000};
      6'd31: r = {1'b1, 3'd5, 5'b00000};
      6'd32: r = {1'b1, 3'd5, 5'b00001};
      6'd33: r = {1'b1, 3'd5, 5'b00011};
      6'd34: r = {1'b1, 3'd5, 5'b00111};
      6'd35: r = {1'b1, 3'd5, 5'b01111};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t            state;
  logic [CW-1:0]     tick;
  logic [SW-1:0]     sym_idx;
  logic [2:0]        len_q;
  logic [MAXSYM-1:0] pat_q;

  logic [MAXSYM+3:0] rom_word;
  logic              rom_vld;
  logic [2:0]        rom_len;
  logic [MAXSYM-1:0] rom_pat;
  logic              last_sym;
  logic [CW-1:0]     mark_last;

  assign rom_word  = rom(char_code);
  assign rom_vld   = rom_word[MAXSYM+3];
  assign rom_len   = rom_word[MAXSYM+2:MAXSYM];
  assign rom_pat   = rom_word[MAXSYM-1:0];
  assign last_sym  = (3'(sym_idx) == (len_q - 3'd1));
  assign mark_last = pat_q[sym_idx] ? DASH_LAST : UNIT_LAST;

  // Code/pattern latches are data and only load on acceptance; the rest is control
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      sym_idx <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      key_out <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (rom_vld) begin
              len_q   <= rom_len;
              pat_q   <= rom_pat;
              sym_idx <= '0;
              tick    <= '0;
              key_out <= 1'b1;
              ready   <= 1'b0;
              busy    <= 1'b1;
              state   <= MARK;
            end else begin
              err <= 1'b1;
            end
          end
        end
        MARK: begin
          if (tick == mark_last) begin
            tick    <= '0;
            key_out <= 1'b0;
            state   <= last_sym ? LGAP : GAP;
          end else begin
            tick <= tick + CW'(1);
          end
        end
        GAP: begin
          if (tick == UNIT_LAST) begin
            tick    <= '0;
            sym_idx <= sym_idx + SW'(1);
            key_out <= 1'b1;
            state   <= MARK;
          end else begin
            tick <= tick + CW'(1);
          end
        end
        LGAP: begin
          if (tick == DASH_LAST) begin
            tick    <= '0;
            sym_idx <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            tick <= tick + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed self-checking bench for morse_encoder with TICKS_PER_UNIT = 4.
module tb_morse_encoder;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] char_code;
  logic       ready, busy, key_out, done, err;

  int checks = 0;
  int errors = 0;

  morse_encoder #(.TICKS_PER_UNIT(4)) dut (
    .CLK(CLK), .reset(reset), .start(start), .char_code(char_code),
    .ready(ready), .busy(busy), .key_out(key_out), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, ".ready"}, ready, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".key"}, key_out, 1'b0);
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".err"}, err, exp_err);
  endtask

  // n busy cycles with key_out held at k, then advance
  task automatic seg(input string tag, input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".key"}, key_out, k);
      chk({tag, ".ready"}, ready, 1'b0);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".done"}, done, 1'b0);
      chk({tag, ".err"}, err, 1'b0);
      step();
    end
  endtask

  task automatic accept(input logic [5:0] code);
    start = 1'b1;
    char_code = code;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    char_code = 6'd0;
    step();
    step();
    reset = 1'b0;
    chk_idle("reset", 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle", 1'b0, 1'b0);
    end

    // 'A' = .-
    step();
    accept(6'd0);
    seg("A.dot", 1'b1, 4);
    seg("A.gap", 1'b0, 4);
    seg("A.dash", 1'b1, 12);
    seg("A.lgap", 1'b0, 12);
    chk_idle("A.done", 1'b1, 1'b0);
    step();
    chk_idle("A.after", 1'b0, 1'b0);

    // 'E' then 'T' accepted in E's done cycle
    step();
    accept(6'd4);
    seg("E.dot", 1'b1, 4);
    seg("E.lgap", 1'b0, 12);
    chk_idle("E.done", 1'b1, 1'b0);
    accept(6'd19);
    seg("T.dash", 1'b1, 12);
    seg("T.lgap", 1'b0, 12);
    chk_idle("T.done", 1'b1, 1'b0);
    step();

    // invalid code 40
    accept(6'd40);
    chk_idle("err40", 1'b0, 1'b1);
    step();
    chk_idle("err40.after", 1'b0, 1'b0);

    // code 30: digit '4' when enabled, otherwise invalid
`ifdef MORSE_DIGITS_EN
    accept(6'd30);
    for (int s = 0; s < 4; s++) begin
      seg("D4.dot", 1'b1, 4);
      seg("D4.gap", 1'b0, 4);
    end
    seg("D4.dash", 1'b1, 12);
    seg("D4.lgap", 1'b0, 12);
    chk_idle("D4.done", 1'b1, 1'b0);
    step();
    chk_idle("D4.after", 1'b0, 1'b0);
`else
    accept(6'd30);
    chk_idle("err30", 1'b0, 1'b1);
    step();
    chk_idle("err30.after", 1'b0, 1'b0);
`endif

    // 'O' = --- aborted by reset in the middle of the second dash
    step();
    accept(6'd14);
    seg("O.dash1", 1'b1, 12);
    seg("O.gap1", 1'b0, 4);
    seg("O.dash2", 1'b1, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("O.reset", 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step();
      chk_idle("O.quiet", 1'b0, 1'b0);
    end
    accept(6'd4);
    seg("E2.dot", 1'b1, 4);
    seg("E2.lgap", 1'b0, 12);
    chk_idle("E2.done", 1'b1, 1'b0);
    step();

    // 'S' = ... with stray starts during cycles 3 and 6
    accept(6'd18);
    for (int k = 1; k <= 32; k++) begin
      logic exp_key;
      exp_key = (k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20);
      chk("S.key", key_out, exp_key);
      chk("S.busy", busy, 1'b1);
      chk("S.ready", ready, 1'b0);
      chk("S.done", done, 1'b0);
      chk("S.err", err, 1'b0);
      if (k == 3 || k == 6) begin
        start = 1'b1;
        char_code = 6'd4;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk_idle("S.done", 1'b1, 1'b0);
    step();
    chk_idle("S.after", 1'b0, 1'b0);
    step();
    chk_idle("S.after2", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
